branch_resolution_unit: RTL and testbench
=========================================

# branch_resolution_unit

Registered branch-resolution stage directly downstream of the 3-way superscalar execute stage. It collects the per-FU misprediction, correct-PC and predictor-update outputs, picks the oldest mispredicting branch by ROB age, and drives one flush/redirect request to the ROB, the reservation stations and fetch. It holds that request until fetch acknowledges it, and suppresses predictor updates from branches younger than a pending flush.

## Interface
- DATA_WIDTH, 32, PC/data width
- ROB_IDX_W, 5, ROB index width (32-entry ROB)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- fu_valid  in  3  bit i: FU i issued an instruction this cycle (issue_valid)
- fu_mispredict  in  3  bit i: FU i misprediction (misprediction_i)
- fu_update_predictor  in  3  bit i: FU i resolved a conditional branch (update_predictor_i)
- fu_correct_pc  in  3*DATA_WIDTH  slice i: correct_pc_i
- fu_update_pc  in  3*DATA_WIDTH  slice i: update_pc_i
- fu_rob_idx  in  3*ROB_IDX_W  slice i: ROB index of FU i's instruction
- rob_head  in  ROB_IDX_W  current ROB head (oldest in-flight)
- redirect_ack  in  1  fetch accepted the current redirect
- redirect_valid  out  1  redirect request pending to fetch (level)
- redirect_pc  out  DATA_WIDTH  target PC, bits [1:0] always 0
- flush_valid  out  1  one-cycle pulse: squash everything younger than flush_rob_idx
- flush_rob_idx  out  ROB_IDX_W  ROB index of the mispredicting branch (kept; younger killed)
- pred_update_valid  out  3  registered predictor-update strobes
- pred_update_pc  out  3*DATA_WIDTH  registered update PCs
- pred_update_mispredict  out  3  registered misprediction flags for the predictor

## Operation
- Age of an entry: age = (idx − rob_head) mod 2^ROB_IDX_W, an unsigned ROB_IDX_W-bit subtraction. Smaller age is older. Equal ages cannot occur legally; if they do, the lower FU index wins.
- A candidate is FU i with fu_valid[i] & fu_mispredict[i] & not squashed.
- Squashed means a flush is pending (state REDIRECT, or flush_valid high this cycle) and the FU's age is ≥ the age of the held flush_rob_idx.
- FSM states: IDLE, REDIRECT.
- IDLE, at least one candidate: latch the oldest candidate's correct_pc (force [1:0]=0) and rob_idx. Go to REDIRECT and pulse flush_valid the next cycle.
- IDLE, no candidate: stay in IDLE.
- REDIRECT: redirect_valid=1. A candidate older than the held index replaces pc/idx and re-pulses flush_valid. Younger or equal candidates are ignored.
- REDIRECT & redirect_ack & no older candidate: go to IDLE and deassert redirect_valid next cycle.
- REDIRECT & redirect_ack & older candidate in the same cycle: the replacement wins. Stay in REDIRECT with the new pc/idx and a new flush_valid pulse. The ack applies to the old request only.
- Predictor path: pred_update_valid[i] <= fu_valid[i] & fu_update_predictor[i] & not squashed. pred_update_pc and pred_update_mispredict are registered copies of the FU inputs.
- Within one cycle, a non-squashed older branch that mispredicts does not squash the predictor updates of other FUs in the same cycle. Those FUs are squashed from the next cycle onward.

## Timing
- All outputs are registered. Latency from FU input to flush_valid, redirect_valid and pred_update_valid is 1 cycle.
- flush_valid lasts exactly one cycle per accepted or replaced redirect. It is never high in IDLE without the transition to REDIRECT.
- redirect_valid stays stable, with redirect_pc unchanged, until the cycle after redirect_ack, unless it is replaced by an older candidate.
- redirect_ack while redirect_valid=0 is ignored.
- Reset values: state=IDLE and every output is 0 (redirect_valid, redirect_pc, flush_valid, flush_rob_idx, pred_update_*).
- rst asserted in REDIRECT: the pending request is dropped and IDLE is taken the next edge. No flush_valid is emitted in the reset cycle or the following cycle.
- ROB wrap: age arithmetic is modulo 2^ROB_IDX_W. Index 1 with head 30 (age 3) is older than index 31 (age 1)? No: 31 has age 1 and is older. The comparison is always on ages, never on raw indices.

## Test plan
- Single mispredict: rob_head=0, FU1 valid+mispredict, idx=4, pc=0x104 -> next cycle flush_valid=1 for 1 cycle, flush_rob_idx=4, redirect_pc=0x104, redirect_valid=1. Hold ack low 3 cycles -> outputs stable. Ack -> redirect_valid=0 the next cycle.
- Three simultaneous mispredicts: idx 7, 3 and 5, head=2, pcs 0x200, 0x300 and 0x400 -> flush_rob_idx=3, redirect_pc=0x300, one flush_valid pulse.
- Wrap-around: head=30, FU0 idx=1, FU2 idx=31 -> FU2 selected (age 1 vs 3). flush_rob_idx=31.
- Replacement during REDIRECT: pending idx=10, then an older idx=8 arrives with ack in the same cycle -> flush_valid re-pulses, flush_rob_idx=8, redirect_valid stays 1. A younger idx=12 is ignored, and its pred_update_valid stays 0.
- Predictor path: FU0 valid+update_predictor with update_pc=0x80, no mispredict -> pred_update_valid=3'b001 and pred_update_pc[0]=0x80 for 1 cycle. No redirect.
- Reset mid-REDIRECT: assert rst for 1 cycle -> all outputs 0 the next cycle, state IDLE. A subsequent mispredict behaves as in the first scenario.

Source files
------------

// File: rtl/branch_resolution_unit_if.sv
// Bundle between the execute stage, the branch resolution unit, and its ROB/RS/fetch consumers.
// The slave modport is the resolution unit's view; master is the surrounding pipeline's.
interface branch_resolution_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROB_IDX_W  = 5
) ();
  logic [2:0]              fu_valid;
  logic [2:0]              fu_mispredict;
  logic [2:0]              fu_update_predictor;
  logic [3*DATA_WIDTH-1:0] fu_correct_pc;
  logic [3*DATA_WIDTH-1:0] fu_update_pc;
  logic [3*ROB_IDX_W-1:0]  fu_rob_idx;
  logic [ROB_IDX_W-1:0]    rob_head;
  logic                    redirect_ack;

  logic                    redirect_valid;
  logic [DATA_WIDTH-1:0]   redirect_pc;
  logic                    flush_valid;
  logic [ROB_IDX_W-1:0]    flush_rob_idx;
  logic [2:0]              pred_update_valid;
  logic [3*DATA_WIDTH-1:0] pred_update_pc;
  logic [2:0]              pred_update_mispredict;

  modport slave (
    input  fu_valid, fu_mispredict, fu_update_predictor, fu_correct_pc, fu_update_pc,
           fu_rob_idx, rob_head, redirect_ack,
    output redirect_valid, redirect_pc, flush_valid, flush_rob_idx, pred_update_valid,
           pred_update_pc, pred_update_mispredict
  );

  modport master (
    output fu_valid, fu_mispredict, fu_update_predictor, fu_correct_pc, fu_update_pc,
           fu_rob_idx, rob_head, redirect_ack,
    input  redirect_valid, redirect_pc, flush_valid, flush_rob_idx, pred_update_valid,
           pred_update_pc, pred_update_mispredict
  );
endinterface

// File: rtl/branch_resolution_unit.sv
// Picks the oldest mispredicting branch of three FUs by ROB age and holds one flush/redirect
// request until fetch acknowledges it; squashes predictor updates younger than a pending flush.
module branch_resolution_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROB_IDX_W  = 5
) (
  input logic                      clk,
  input logic                      rst,
  branch_resolution_unit_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRedirect} state_e;

  state_e                state_q;
  logic [ROB_IDX_W-1:0]  age [3];
  logic [ROB_IDX_W-1:0]  held_age;
  logic [ROB_IDX_W-1:0]  best_age;
  logic                  pending;
  logic                  any_cand;
  logic [2:0]            squashed;
  logic [2:0]            cand;
  logic [DATA_WIDTH-1:0] sel_pc;
  logic [ROB_IDX_W-1:0]  sel_idx;

  always_comb begin
    held_age = bus.flush_rob_idx - bus.rob_head;
    pending  = (state_q == StRedirect) || bus.flush_valid;
    best_age = '1;
    any_cand = 1'b0;
    squashed = '0;
    cand     = '0;
    sel_pc   = '0;
    sel_idx  = '0;
    for (int i = 0; i < 3; i++) begin
      age[i]      = bus.fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W] - bus.rob_head;
      squashed[i] = pending && (age[i] >= held_age);
      cand[i]     = bus.fu_valid[i] && bus.fu_mispredict[i] && !squashed[i];
      // Strict compare: on an (illegal) age tie the lower FU index keeps the slot.
      if (cand[i] && (!any_cand || (age[i] < best_age))) begin
        any_cand = 1'b1;
        best_age = age[i];
        sel_pc   = {bus.fu_correct_pc[i*DATA_WIDTH+2 +: DATA_WIDTH-2], 2'b00};
        sel_idx  = bus.fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                    <= StIdle;
      bus.redirect_valid         <= 1'b0;
      bus.redirect_pc            <= '0;
      bus.flush_valid            <= 1'b0;
      bus.flush_rob_idx          <= '0;
      bus.pred_update_valid      <= '0;
      bus.pred_update_pc         <= '0;
      bus.pred_update_mispredict <= '0;
    end else begin
      bus.pred_update_valid      <= bus.fu_valid & bus.fu_update_predictor & ~squashed;
      bus.pred_update_pc         <= bus.fu_update_pc;
      bus.pred_update_mispredict <= bus.fu_mispredict;
      bus.flush_valid            <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_cand) begin
            state_q            <= StRedirect;
            bus.redirect_valid <= 1'b1;
            bus.redirect_pc    <= sel_pc;
            bus.flush_rob_idx  <= sel_idx;
            bus.flush_valid    <= 1'b1;
          end
        end
        StRedirect: begin
          // Any surviving candidate here is older than the held one, so it replaces it even
          // when fetch acks the old request in the same cycle.
          if (any_cand) begin
            bus.redirect_pc   <= sel_pc;
            bus.flush_rob_idx <= sel_idx;
            bus.flush_valid   <= 1'b1;
          end else if (bus.redirect_ack) begin
            state_q            <= StIdle;
            bus.redirect_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed table-driven bench for branch_resolution_unit with hand-computed expectations.
module tb_branch_resolution_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolution_unit_if #(.DATA_WIDTH(32), .ROB_IDX_W(5)) bus ();

  branch_resolution_unit #(.DATA_WIDTH(32), .ROB_IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [2:0]  m;
    logic [2:0]  u;
    logic [4:0]  head;
    logic [14:0] idx;
    logic [95:0] cpc;
    logic [95:0] upc;
    logic        ack;
    logic        erv;
    logic [31:0] erpc;
    logic        efv;
    logic [4:0]  efidx;
    logic [2:0]  epuv;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [2:0] v, logic [2:0] m, logic [2:0] u,
                              logic [4:0] head, logic [14:0] idx, logic [95:0] cpc,
                              logic [95:0] upc, logic ack, logic erv, logic [31:0] erpc,
                              logic efv, logic [4:0] efidx, logic [2:0] epuv);
    vec_t t;
    t.rst = r; t.v = v; t.m = m; t.u = u; t.head = head; t.idx = idx; t.cpc = cpc;
    t.upc = upc; t.ack = ack; t.erv = erv; t.erpc = erpc; t.efv = efv; t.efidx = efidx;
    t.epuv = epuv;
    return t;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string tag);
    rst                     = t.rst;
    bus.fu_valid            = t.v;
    bus.fu_mispredict       = t.m;
    bus.fu_update_predictor = t.u;
    bus.rob_head            = t.head;
    bus.fu_rob_idx          = t.idx;
    bus.fu_correct_pc       = t.cpc;
    bus.fu_update_pc        = t.upc;
    bus.redirect_ack        = t.ack;
    @(posedge clk);
    #1;
    chk({tag, " redirect_valid"}, 96'(bus.redirect_valid), 96'(t.erv));
    chk({tag, " redirect_pc"}, 96'(bus.redirect_pc), 96'(t.erpc));
    chk({tag, " flush_valid"}, 96'(bus.flush_valid), 96'(t.efv));
    chk({tag, " flush_rob_idx"}, 96'(bus.flush_rob_idx), 96'(t.efidx));
    chk({tag, " pred_update_valid"}, 96'(bus.pred_update_valid), 96'(t.epuv));
    chk({tag, " pred_update_mispredict"}, 96'(bus.pred_update_mispredict),
        t.rst ? 96'(0) : 96'(t.m));
    chk({tag, " pred_update_pc"}, bus.pred_update_pc, t.rst ? 96'(0) : t.upc);
  endtask

  localparam logic [95:0] Z = '0;

  initial begin
    rst = 1'b1;
    bus.fu_valid = '0; bus.fu_mispredict = '0; bus.fu_update_predictor = '0;
    bus.fu_correct_pc = '0; bus.fu_update_pc = '0; bus.fu_rob_idx = '0;
    bus.rob_head = '0; bus.redirect_ack = 1'b0;

    //         rst v     m     u     head   idx                    cpc / upc                ack
    //         erv erpc        efv efidx puv
    vecs.push_back(mk(1, 3'b000, 3'b000, 3'b000, 5'd0, 15'd0, Z, Z, 0, 0, 32'h0, 0, 5'd0, 3'b000));
    // Single mispredict on FU1, held three cycles, then acked.
    vecs.push_back(mk(0, 3'b010, 3'b010, 3'b000, 5'd0, {5'd0, 5'd4, 5'd0},
                      {32'h0, 32'h104, 32'h0}, Z, 0, 1, 32'h104, 1, 5'd4, 3'b000));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 5'd0, 15'd0, Z, Z, 0,
                        1, 32'h104, 0, 5'd4, 3'b000));
    vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 5'd0, 15'd0, Z, Z, 1, 0, 32'h104, 0, 5'd4, 3'b000));
    // Ack while idle is ignored.
    vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 5'd0, 15'd0, Z, Z, 1, 0, 32'h104, 0, 5'd4, 3'b000));
    // Three mispredicts, head 2: ages 5,1,3 -> FU1; same-cycle predictor updates all survive.
    vecs.push_back(mk(0, 3'b111, 3'b111, 3'b111, 5'd2, {5'd5, 5'd3, 5'd7},
                      {32'h400, 32'h300, 32'h200}, {32'h410, 32'h310, 32'h210}, 0,
                      1, 32'h300, 1, 5'd3, 3'b111));
    vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 5'd2, 15'd0, Z, Z, 1, 0, 32'h300, 0, 5'd3, 3'b000));
    // Wrap: head 30, idx 1 (age 3) vs idx 31 (age 1); pc low bits forced to zero.
    vecs.push_back(mk(0, 3'b101, 3'b101, 3'b000, 5'd30, {5'd31, 5'd0, 5'd1},
                      {32'h603, 32'h0, 32'h500}, Z, 0, 1, 32'h600, 1, 5'd31, 3'b000));
    vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 5'd30, 15'd0, Z, Z, 1, 0, 32'h600, 0, 5'd31, 3'b000));
    // Replacement: pending 10, older 8 with ack; younger 12 update squashed.
    vecs.push_back(mk(0, 3'b001, 3'b001, 3'b000, 5'd0, {5'd0, 5'd0, 5'd10},
                      {32'h0, 32'h0, 32'h1000}, Z, 0, 1, 32'h1000, 1, 5'd10, 3'b000));
    vecs.push_back(mk(0, 3'b110, 3'b010, 3'b110, 5'd0, {5'd12, 5'd8, 5'd0},
                      {32'hc00, 32'h800, 32'h0}, {32'hc0, 32'h88, 32'h0}, 1,
                      1, 32'h800, 1, 5'd8, 3'b010));
    vecs.push_back(mk(0, 3'b100, 3'b100, 3'b100, 5'd0, {5'd12, 5'd0, 5'd0},
                      {32'hc00, 32'h0, 32'h0}, {32'hc0, 32'h0, 32'h0}, 0,
                      1, 32'h800, 0, 5'd8, 3'b000));
    // Equal age to the held index is ignored.
    vecs.push_back(mk(0, 3'b001, 3'b001, 3'b001, 5'd0, {5'd0, 5'd0, 5'd8},
                      {32'h0, 32'h0, 32'h900}, Z, 0, 1, 32'h800, 0, 5'd8, 3'b000));
    vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 5'd0, 15'd0, Z, Z, 1, 0, 32'h800, 0, 5'd8, 3'b000));
    // Plain predictor update, no redirect.
    vecs.push_back(mk(0, 3'b001, 3'b000, 3'b001, 5'd0, 15'd0, Z, {64'h0, 32'h80}, 0,
                      0, 32'h800, 0, 5'd8, 3'b001));
    vecs.push_back(mk(0, 3'b000, 3'b000, 3'b000, 5'd0, 15'd0, Z, Z, 0, 0, 32'h800, 0, 5'd8, 3'b000));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Reset mid-REDIRECT: drop the request, no flush afterwards, then a fresh mispredict.
    apply(mk(0, 3'b010, 3'b010, 3'b000, 5'd0, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h104, 32'h0}, Z, 0,
             1, 32'h104, 1, 5'd4, 3'b000), "rs_enter");
    apply(mk(1, 3'b001, 3'b001, 3'b001, 5'd0, {5'd0, 5'd0, 5'd2}, {32'h0, 32'h0, 32'h700}, Z, 0,
             0, 32'h0, 0, 5'd0, 3'b000), "rs_reset");
    apply(mk(0, 3'b000, 3'b000, 3'b000, 5'd0, 15'd0, Z, Z, 0, 0, 32'h0, 0, 5'd0, 3'b000),
          "rs_after");
    apply(mk(0, 3'b010, 3'b010, 3'b000, 5'd0, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h104, 32'h0}, Z, 0,
             1, 32'h104, 1, 5'd4, 3'b000), "rs_again");
    apply(mk(0, 3'b000, 3'b000, 3'b000, 5'd0, 15'd0, Z, Z, 1, 0, 32'h104, 0, 5'd4, 3'b000),
          "rs_ack");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
